// File: rtl/lc3b_decode_regfile.sv
// lc3b_decode_regfile: LC-3b register file and NZP register with bypassed reads, a pending-write scoreboard and a RAW stall
module lc3b_decode_regfile #(
    parameter int NREGS  = 8,
    parameter int PEND_W = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wb_valid,
    input  logic [2:0]        wb_dest,
    input  logic [15:0]       wb_data,
    input  logic              wb_load_cc,
    input  logic [2:0]        wb_cc,
    input  logic              id_valid,
    input  logic [2:0]        id_sr1,
    input  logic [2:0]        id_sr2,
    input  logic              id_use_sr1,
    input  logic              id_use_sr2,
    input  logic              id_use_cc,
    input  logic              id_wr_dr,
    input  logic [2:0]        id_dr,
    input  logic              id_set_cc,
    input  logic              flush,
    output logic [15:0]       sr1_data,
    output logic [15:0]       sr2_data,
    output logic [2:0]        cc_out,
    output logic              stall,
    output logic [NREGS-1:0]  busy_vec,
    output logic              sb_error
);
    localparam logic [PEND_W-1:0] PMAX = '1;
    localparam logic [PEND_W-1:0] PONE = PEND_W'(1);

    logic [15:0]       regs [NREGS];
    logic [2:0]        cc;
    logic [PEND_W-1:0] pend [NREGS];
    logic [PEND_W-1:0] cc_pend;
    logic              haz1, haz2, hazc, hazs, issue, inc_dr, uf_reg, uf_cc;

    // A counter steps by the net of one increment and one decrement, saturating at zero on underflow
    function automatic logic [PEND_W-1:0] next_cnt(input logic [PEND_W-1:0] c, input logic inc, input logic dec);
        return (inc == dec) ? c : inc ? c + 1'b1 : (c == '0) ? c : c - 1'b1;
    endfunction

    assign sr1_data = (wb_valid && wb_dest == id_sr1) ? wb_data : regs[id_sr1];
    assign sr2_data = (wb_valid && wb_dest == id_sr2) ? wb_data : regs[id_sr2];
    assign cc_out   = wb_load_cc ? wb_cc : cc;

    assign haz1  = id_use_sr1 && pend[id_sr1] != '0 && !(pend[id_sr1] == PONE && wb_valid && wb_dest == id_sr1);
    assign haz2  = id_use_sr2 && pend[id_sr2] != '0 && !(pend[id_sr2] == PONE && wb_valid && wb_dest == id_sr2);
    assign hazc  = id_use_cc && cc_pend != '0 && !(cc_pend == PONE && wb_load_cc);
    assign hazs  = (id_wr_dr && pend[id_dr] == PMAX) || (id_set_cc && cc_pend == PMAX);
    assign stall = id_valid && !flush && (haz1 || haz2 || hazc || hazs);
    assign issue = id_valid && !stall && !flush;

    assign inc_dr = issue && id_wr_dr;
    assign uf_reg = wb_valid && pend[wb_dest] == '0 && !(inc_dr && id_dr == wb_dest);
    assign uf_cc  = wb_load_cc && cc_pend == '0 && !(issue && id_set_cc);

    // Busy view of the registered pending counters
    always_comb begin
        busy_vec = '0;
        for (int i = 0; i < NREGS; i++) busy_vec[i] = pend[i] != '0;
    end

    // Architectural state, scoreboard counters and the sticky underflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
            cc       <= 3'b010;
            cc_pend  <= '0;
            sb_error <= 1'b0;
        end else begin
            if (wb_valid) regs[wb_dest] <= wb_data;
            if (wb_load_cc) cc <= wb_cc;
            for (int i = 0; i < NREGS; i++)
                pend[i] <= flush ? '0 : next_cnt(pend[i], inc_dr && id_dr == 3'(i), wb_valid && wb_dest == 3'(i));
            cc_pend <= flush ? '0 : next_cnt(cc_pend, issue && id_set_cc, wb_load_cc);
            if (!flush && (uf_reg || uf_cc)) sb_error <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lc3b_decode_regfile.sv
// tb_lc3b_decode_regfile: directed scoreboard bench for the decode register file
module tb_lc3b_decode_regfile;
    logic        clk = 0;
    logic        reset_n;
    logic        wb_valid, wb_load_cc, id_valid, id_use_sr1, id_use_sr2, id_use_cc, id_wr_dr, id_set_cc, flush;
    logic [2:0]  wb_dest, wb_cc, id_sr1, id_sr2, id_dr;
    logic [15:0] wb_data;
    logic [15:0] sr1_data, sr2_data;
    logic [2:0]  cc_out;
    logic        stall, sb_error;
    logic [7:0]  busy_vec;

    typedef struct {
        string       name;
        logic [15:0] sr1;
        logic [15:0] sr2;
        logic [2:0]  cc;
        logic        stall;
        logic [7:0]  busy;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;

    lc3b_decode_regfile dut (
        .clk(clk), .reset_n(reset_n),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .wb_load_cc(wb_load_cc), .wb_cc(wb_cc),
        .id_valid(id_valid), .id_sr1(id_sr1), .id_sr2(id_sr2),
        .id_use_sr1(id_use_sr1), .id_use_sr2(id_use_sr2), .id_use_cc(id_use_cc),
        .id_wr_dr(id_wr_dr), .id_dr(id_dr), .id_set_cc(id_set_cc), .flush(flush),
        .sr1_data(sr1_data), .sr2_data(sr2_data), .cc_out(cc_out),
        .stall(stall), .busy_vec(busy_vec), .sb_error(sb_error)
    );

    always #5 clk = ~clk;

    task automatic idle();
        wb_valid = 0; wb_dest = 0; wb_data = 0; wb_load_cc = 0; wb_cc = 0;
        id_valid = 0; id_sr1 = 0; id_sr2 = 0; id_use_sr1 = 0; id_use_sr2 = 0;
        id_use_cc = 0; id_wr_dr = 0; id_dr = 0; id_set_cc = 0; flush = 0;
    endtask

    task automatic expect_out(input string n, input logic [15:0] s1, input logic [15:0] s2, input logic [2:0] c,
                              input logic st, input logic [7:0] b, input logic e);
        exp_t x;
        x.name = n; x.sr1 = s1; x.sr2 = s2; x.cc = c; x.stall = st; x.busy = b; x.err = e;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_wr(input logic [2:0] dr);
        idle(); id_valid = 1; id_wr_dr = 1; id_dr = dr;
    endtask

    task automatic chk(input string n, input string f, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", n, f, act, req);
        end
    endtask

    // Monitor: sample mid-cycle and compare against the oldest pending expectation
    initial begin
        int cyc = 0;
        exp_t x;
        forever begin
            @(negedge clk);
            cyc++;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk(x.name, "sr1_data", sr1_data, x.sr1);
                chk(x.name, "sr2_data", sr2_data, x.sr2);
                chk(x.name, "cc_out", 16'(cc_out), 16'(x.cc));
                chk(x.name, "stall", 16'(stall), 16'(x.stall));
                chk(x.name, "busy_vec", 16'(busy_vec), 16'(x.busy));
                chk(x.name, "sb_error", 16'(sb_error), 16'(x.err));
            end
            if (done || cyc > 2000) begin
                checks++;
                if (q.size() != 0 || !done) begin
                    errors++;
                    $display("FAIL drain: %0d expectations left, done=%0d", q.size(), done);
                end
                $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        idle();
        reset_n = 0;
        step();
        id_sr1 = 3; id_sr2 = 5;
        expect_out("in_reset", 16'h0000, 16'h0000, 3'b010, 0, 8'h00, 0);
        step();
        reset_n = 1;

        idle(); id_valid = 1; id_sr1 = 3; id_sr2 = 5; id_use_sr1 = 1; id_use_sr2 = 1;
        expect_out("rd_after_reset", 16'h0000, 16'h0000, 3'b010, 0, 8'h00, 0); step();
        issue_wr(2);
        expect_out("issue_add_r2", 16'h0000, 16'h0000, 3'b010, 0, 8'h00, 0); step();
        idle(); id_valid = 1; id_use_sr1 = 1; id_sr1 = 2;
        expect_out("raw_stall_r2", 16'h0000, 16'h0000, 3'b010, 1, 8'h04, 0); step();
        wb_valid = 1; wb_dest = 2; wb_data = 16'h1234;
        expect_out("wb_bypass_r2", 16'h1234, 16'h0000, 3'b010, 0, 8'h04, 0); step();
        idle(); id_sr1 = 2; id_sr2 = 2;
        expect_out("busy_clear", 16'h1234, 16'h1234, 3'b010, 0, 8'h00, 0); step();

        issue_wr(4);
        expect_out("r4_issue_a", 16'h0000, 16'h0000, 3'b010, 0, 8'h00, 0); step();
        expect_out("r4_issue_b", 16'h0000, 16'h0000, 3'b010, 0, 8'h10, 0); step();
        expect_out("r4_issue_c", 16'h0000, 16'h0000, 3'b010, 0, 8'h10, 0); step();
        expect_out("r4_full_stall", 16'h0000, 16'h0000, 3'b010, 1, 8'h10, 0); step();
        id_sr1 = 4; wb_valid = 1; wb_dest = 4; wb_data = 16'h00AA;
        expect_out("r4_wb_still_full", 16'h00AA, 16'h0000, 3'b010, 1, 8'h10, 0); step();
        issue_wr(4); id_sr1 = 4;
        expect_out("r4_fourth_issues", 16'h00AA, 16'h0000, 3'b010, 0, 8'h10, 0); step();

        issue_wr(3); id_set_cc = 1;
        expect_out("ld_set_cc", 16'h0000, 16'h0000, 3'b010, 0, 8'h10, 0); step();
        idle(); id_valid = 1; id_use_cc = 1;
        expect_out("br_cc_stall", 16'h0000, 16'h0000, 3'b010, 1, 8'h18, 0); step();
        id_sr1 = 3; wb_load_cc = 1; wb_cc = 3'b100; wb_valid = 1; wb_dest = 3; wb_data = 16'h5555;
        expect_out("cc_bypass", 16'h5555, 16'h0000, 3'b100, 0, 8'h18, 0); step();
        idle(); id_sr1 = 3; id_sr2 = 4;
        expect_out("cc_committed", 16'h5555, 16'h00AA, 3'b100, 0, 8'h10, 0); step();

        issue_wr(1);
        expect_out("issue_r1", 16'h0000, 16'h0000, 3'b100, 0, 8'h10, 0); step();
        issue_wr(1); id_sr1 = 1; wb_valid = 1; wb_dest = 1; wb_data = 16'h0101;
        expect_out("r1_inc_dec", 16'h0101, 16'h0000, 3'b100, 0, 8'h12, 0); step();
        idle(); id_sr1 = 1; id_sr2 = 2;
        expect_out("r1_still_busy", 16'h0101, 16'h1234, 3'b100, 0, 8'h12, 0); step();
        idle(); id_sr1 = 6; wb_valid = 1; wb_dest = 6; wb_data = 16'hBEEF;
        expect_out("stray_wb_r6", 16'hBEEF, 16'h0000, 3'b100, 0, 8'h12, 0); step();
        idle(); id_sr1 = 6;
        expect_out("sb_error_sticky", 16'hBEEF, 16'h0000, 3'b100, 0, 8'h12, 1); step();

        issue_wr(2); id_set_cc = 1;
        expect_out("pend_r2_a", 16'h0000, 16'h0000, 3'b100, 0, 8'h12, 1); step();
        issue_wr(2);
        expect_out("pend_r2_b", 16'h0000, 16'h0000, 3'b100, 0, 8'h16, 1); step();
        idle(); id_valid = 1; id_use_sr1 = 1; id_sr1 = 2; id_use_cc = 1;
        expect_out("pre_flush_stall", 16'h1234, 16'h0000, 3'b100, 1, 8'h16, 1); step();
        flush = 1; wb_valid = 1; wb_dest = 2; wb_data = 16'h2222;
        expect_out("flush", 16'h2222, 16'h0000, 3'b100, 0, 8'h16, 1); step();
        idle(); id_valid = 1; id_use_sr1 = 1; id_sr1 = 2; id_use_cc = 1;
        expect_out("post_flush", 16'h2222, 16'h0000, 3'b100, 0, 8'h00, 1); step();
        issue_wr(7);
        expect_out("issue_r7", 16'h0000, 16'h0000, 3'b100, 0, 8'h00, 1); step();
        idle();
        expect_out("pre_async_rst", 16'h0000, 16'h0000, 3'b100, 0, 8'h80, 1); step();

        #1;
        reset_n = 0;
        id_valid = 1; id_use_sr1 = 1; id_sr1 = 2; id_sr2 = 6;
        expect_out("async_reset", 16'h0000, 16'h0000, 3'b010, 0, 8'h00, 0);
        step();
        done = 1;
    end
endmodule

// File: doc/lc3b_decode_regfile.md
Name: lc3b_decode_regfile

Overview:
Decode-side consumer of the store/writeback stage. Holds the eight 16-bit LC-3b general registers and the NZP condition-code register. Serves two combinational read ports to decode with write-through bypass. Keeps a per-register and CC pending-write scoreboard, and raises stall for read-after-write hazards until the matching writeback arrives.

Parameters:
NREGS, 8, number of architectural registers (index width 3).
PEND_W, 2, width of each pending-write counter; maximum in-flight writes per target = 2^PEND_W-1.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
wb_valid  in  1  writeback stage writes wb_data to wb_dest this cycle
wb_dest  in  3  destination register index
wb_data  in  16  value selected by the writeback mux
wb_load_cc  in  1  writeback updates CC this cycle
wb_cc  in  3  NZP from the writeback gencc
id_valid  in  1  decode holds a valid instruction
id_sr1  in  3  source 1 index
id_sr2  in  3  source 2 index
id_use_sr1  in  1  instruction reads sr1
id_use_sr2  in  1  instruction reads sr2
id_use_cc  in  1  instruction reads CC (BR)
id_wr_dr  in  1  instruction will write a register
id_dr  in  3  destination index
id_set_cc  in  1  instruction will write CC
flush  in  1  squash decode and all younger in-flight instructions
sr1_data  out  16  register sr1 value, bypassed
sr2_data  out  16  register sr2 value, bypassed
cc_out  out  3  CC value, bypassed
stall  out  1  hold decode; no issue this cycle
busy_vec  out  8  bit i = pending[i] != 0 (registered state)
sb_error  out  1  sticky; writeback to a target whose pending count is 0

Behaviour:
- Reset (async, reset_n=0): all registers 0; CC = 3'b010 (Z); all pending counters 0; sb_error 0. Outputs follow state combinationally, so stall=0 and busy_vec=0 during reset.
- Register write: on the rising edge with wb_valid, reg[wb_dest] <= wb_data. CC write: with wb_load_cc, CC <= wb_cc.
- Read ports (combinational, 0 latency): sr1_data = wb_data if wb_valid && wb_dest==id_sr1, else reg[id_sr1]. sr2_data uses the same rule. cc_out = wb_cc if wb_load_cc, else CC.
- Hazard on a source: use_srX && pending[srX]!=0 && !(pending[srX]==1 && wb_valid && wb_dest==srX).
- CC hazard: id_use_cc && cc_pend!=0 && !(cc_pend==1 && wb_load_cc).
- Structural hazard: id_wr_dr && pending[id_dr] at maximum, or id_set_cc && cc_pend at maximum.
- stall = id_valid && !flush && (any hazard).
- issue = id_valid && !stall && !flush.
- Counter update per edge:
  - pending[id_dr] += issue && id_wr_dr.
  - pending[wb_dest] -= wb_valid.
  - Increment and decrement of the same index in one cycle: net unchanged.
  - CC counter uses id_set_cc / wb_load_cc with the same rules.
- Underflow: a decrement at count 0 leaves the counter at 0 and sets sb_error (sticky until reset). The data write still occurs.
- flush: all pending counters and cc_pend <= 0 on that edge, overriding increments and decrements. Register and CC writes in the same cycle still commit. Writebacks arriving after a flush from squashed instructions must not occur (pipeline contract). Older writebacks are treated as already retired.
- Simultaneous wb and read of R0..R7: the bypass returns the new value in the same cycle. There is no special zero register.

Test Plan:
- Reset, then read sr1=3, sr2=5 -> both 0x0000, cc_out=3'b010, stall=0, busy_vec=0.
- Issue ADD R2 (id_wr_dr, id_dr=2). Next cycle read sr1=2 -> stall=1, busy_vec=8'h04. Next cycle wb R2=0x1234 -> stall=0 that cycle, sr1_data=0x1234; busy_vec=0 after the edge.
- Issue three writes to R4 back to back -> pending[4]=3. A fourth write to R4 -> stall=1. Next wb R4 -> pending 2, the fourth issues.
- Issue LD with id_set_cc, then BR (id_use_cc) -> stall. wb_load_cc with wb_cc=3'b100 -> cc_out=3'b100 same cycle, stall drops.
- Issue to R1 and wb R1 in the same cycle with pending[1]=1 -> pending stays 1. Then a stray wb R6 with pending[6]=0 -> sb_error=1, reg[6] updated.
- pending[2]=2, cc_pend=1, then flush -> busy_vec=0, stall=0 next cycle. Assert reset_n low mid-sequence -> all state cleared asynchronously.
